sdram_write: RTL and testbench
==============================

// Module: sdram_write
// PURPOSE
//  Write-path engine of the wishbone SDRAM slave; the counterpart of the read path.
//  Pops 32-bit words from the write FIFO and writes each word as two 16-bit SDRAM beats.
//  Each word runs ACTIVATE, WRITE top, WRITE bottom, PRECHARGE at consecutive even/odd columns.
//  Services auto-refresh requests while enabled. Shares the SDRAM command bus with the read path under controller arbitration.
// PARAMETERS
//  T_RCD  3   cycles ACT->WRITE
//  T_WR   2   cycles last WRITE->PRE
//  T_RP   3   cycles PRE->next command
//  T_RFC  10  cycles AR->next command
// PORTS
//  clk           in   1   SDRAM clock; all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  command       out  3   {RAS_n,CAS_n,WE_n}: NOP=111 ACT=011 WRITE=100 PRE=010 AR=001
//  addr          out  12  row (ACT) / {4'b0,column} (WRITE) / 0 (PRE, A10=0)
//  bank          out  2   bank select
//  data_out      out  16  write data beat
//  data_oe       out  1   high only in cycles where command==WRITE
//  data_mask     out  2   byte mask, 1 = masked
//  en            in   1   controller grant/enable
//  address       in   22  [21:20] bank, [19:8] row, [7:0] column; bit 0 ignored (forced 0)
//  ready         out  1   comb: state==IDLE && delay==0
//  auto_refresh  in   1   one-cycle refresh request pulse
//  fifo_data     in   32  FIFO word, valid the cycle after fifo_rd; [31:16] written first
//  fifo_empty    in   1   FIFO empty
//  fifo_rd       out  1   registered one-cycle pop strobe
// BEHAVIOUR
//  Reset values:
//  - command=NOP, addr=0, bank=0, data_out=0, data_oe=0, data_mask=0, fifo_rd=0.
//  - state=IDLE, delay=0, laddress=0, lauto_refresh=0; ready=1 after reset.
//  Reset mid-operation aborts at once: no further WRITE/PRE and no pending pop is issued.
//  delay counter: while delay>0, decrement, drive NOP, data_oe=0, state holds.
//  Timing: a command issued with delay<=N-1 is followed by N-1 NOPs, so the next command lands N cycles later.
//  lauto_refresh: set when auto_refresh&en in any state; cleared when AR is issued. A new set in the same cycle wins.
//  IDLE:
//  - lauto_refresh: issue AR, delay<=T_RFC-1, go to REFRESH.
//  - else en&~fifo_empty: laddress<=address (bit0=0), fifo_rd<=1, go to FETCH.
//  FETCH: fifo_rd<=0, go to ACTIVATE.
//  ACTIVATE: wdata<=fifo_data; issue ACT, addr=row, bank; delay<=T_RCD-1; go to WR_TOP.
//  WR_TOP: issue WRITE at column, data_out=wdata[31:16], data_oe=1; go to WR_BOT.
//  WR_BOT:
//  - issue WRITE at column+1, data_out=wdata[15:0], data_oe=1.
//  - laddress<=laddress+2 (22-bit; row/bank carry; 3FFFFE wraps to 0).
//  - delay<=T_WR-1; go to PRECHARGE.
//  PRECHARGE: issue PRE, addr=0, same bank; delay<=T_RP-1; go to DECIDE.
//  DECIDE, in priority order:
//  - lauto_refresh: AR, delay<=T_RFC-1, go to REFRESH.
//  - en&~fifo_empty: fifo_rd<=1, go to FETCH (laddress continues).
//  - otherwise: go to IDLE.
//  REFRESH: go to IDLE.
//  en or fifo_empty falling mid-word: the word completes through PRE, then IDLE.
//  Refresh pulse with en=0: ignored.
//  Throughput: one word per 6+T_RCD+T_WR+T_RP-3 cycles, 11 at defaults, from FETCH to next FETCH.
// CONFIGURATION
//  SDRAM_WRITE_MASK_EN defined:
//  - adds input fifo_mask[3:0], byte enables with 1=write, valid with fifo_data; captured in ACTIVATE.
//  - data_mask=~mask[3:2] on WR_TOP, ~mask[1:0] on WR_BOT, 0 otherwise.
//  Not defined: no fifo_mask port; data_mask tied 2'b00.
// TESTING
//  - addr 22'h2ABC10, FIFO 32'hDEADBEEF, en=1 -> ACT bank2 addr ABC; WRITE 010/DEAD 3 cycles later; WRITE 011/BEEF; PRE 2 cycles later; ready=1.
//  - two words from 22'h0123FE -> second word ACT row 124 column 00; exactly 2 fifo_rd pulses; no third pop.
//  - start 22'h3FFFFE, two words -> second ACT bank0 row 000, WRITE 000/001.
//  - auto_refresh pulse during WR_TOP -> PRE, then AR T_RP later; next ACT T_RFC after AR.
//  - rst asserted during delay after ACT -> next cycle command=NOP, data_oe=0, fifo_rd=0; ready=1; no WRITE.
//  - MASK_EN, fifo_mask=4'b1001 -> data_mask=2'b01 on top beat, 2'b10 on bottom beat.

Source files
------------

// File: rtl/sdram_write.sv
// SDRAM write-path engine: pops 32-bit FIFO words and writes each as two 16-bit beats
// (ACT, WRITE hi, WRITE lo, PRE) and services auto-refresh. Optional byte masks: SDRAM_WRITE_MASK_EN.
module sdram_write #(
    parameter int T_RCD = 3,
    parameter int T_WR  = 2,
    parameter int T_RP  = 3,
    parameter int T_RFC = 10
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  command,
    output logic [11:0] addr,
    output logic [1:0]  bank,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic [1:0]  data_mask,
    input  logic        en,
    input  logic [21:0] address,
    output logic        ready,
    input  logic        auto_refresh,
    input  logic [31:0] fifo_data,
`ifdef SDRAM_WRITE_MASK_EN
    input  logic [3:0]  fifo_mask,
`endif
    input  logic        fifo_empty,
    output logic        fifo_rd
);
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_AR    = 3'b001;

    // T_RFC is the longest wait, so it sizes the delay counter.
    localparam int DW = $clog2(T_RFC + 1);
    localparam logic [DW-1:0] D_RCD = DW'(T_RCD - 1);
    localparam logic [DW-1:0] D_WR  = DW'(T_WR - 1);
    localparam logic [DW-1:0] D_RP  = DW'(T_RP - 1);
    localparam logic [DW-1:0] D_RFC = DW'(T_RFC - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, ACTIVATE, WR_TOP, WR_BOT, PRECHARGE, DECIDE, REFRESH
    } state_t;

    state_t         state, state_n;
    logic [DW-1:0]  delay, delay_n;
    logic [21:0]    laddress, laddress_n;
    logic           lauto_refresh, lauto_refresh_n;
    logic [31:0]    wdata, wdata_n;
    logic [2:0]     command_n;
    logic [11:0]    addr_n;
    logic [1:0]     bank_n;
    logic [15:0]    data_out_n;
    logic           data_oe_n;
    logic           fifo_rd_n;
    logic [1:0]     data_mask_n;
`ifdef SDRAM_WRITE_MASK_EN
    logic [3:0]     wmask, wmask_n;
`endif

    assign ready = (state == IDLE) && (delay == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            delay         <= '0;
            laddress      <= '0;
            lauto_refresh <= 1'b0;
            wdata         <= '0;
            command       <= CMD_NOP;
            addr          <= '0;
            bank          <= '0;
            data_out      <= '0;
            data_oe       <= 1'b0;
            fifo_rd       <= 1'b0;
        end else begin
            state         <= state_n;
            delay         <= delay_n;
            laddress      <= laddress_n;
            lauto_refresh <= lauto_refresh_n;
            wdata         <= wdata_n;
            command       <= command_n;
            addr          <= addr_n;
            bank          <= bank_n;
            data_out      <= data_out_n;
            data_oe       <= data_oe_n;
            fifo_rd       <= fifo_rd_n;
        end
    end

`ifdef SDRAM_WRITE_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wmask     <= '0;
            data_mask <= 2'b00;
        end else begin
            wmask     <= wmask_n;
            data_mask <= data_mask_n;
        end
    end
`else
    assign data_mask = 2'b00;
`endif

    always_comb begin
        state_n         = state;
        delay_n         = delay;
        laddress_n      = laddress;
        lauto_refresh_n = lauto_refresh;
        wdata_n         = wdata;
        command_n       = CMD_NOP;
        addr_n          = addr;
        bank_n          = bank;
        data_out_n      = data_out;
        data_oe_n       = 1'b0;
        fifo_rd_n       = fifo_rd;
        data_mask_n     = 2'b00;
`ifdef SDRAM_WRITE_MASK_EN
        wmask_n         = wmask;
`endif
        if (delay != '0) begin
            delay_n = delay - 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (lauto_refresh) begin
                        command_n       = CMD_AR;
                        lauto_refresh_n = 1'b0;
                        delay_n         = D_RFC;
                        state_n         = REFRESH;
                    end else if (en && !fifo_empty) begin
                        laddress_n = address & 22'h3FFFFE;
                        fifo_rd_n  = 1'b1;
                        state_n    = FETCH;
                    end
                end
                FETCH: begin
                    fifo_rd_n = 1'b0;
                    state_n   = ACTIVATE;
                end
                ACTIVATE: begin
                    wdata_n   = fifo_data;
`ifdef SDRAM_WRITE_MASK_EN
                    wmask_n   = fifo_mask;
`endif
                    command_n = CMD_ACT;
                    addr_n    = laddress[19:8];
                    bank_n    = laddress[21:20];
                    delay_n   = D_RCD;
                    state_n   = WR_TOP;
                end
                WR_TOP: begin
                    command_n  = CMD_WRITE;
                    addr_n     = {4'b0000, laddress[7:0]};
                    data_out_n = wdata[31:16];
                    data_oe_n  = 1'b1;
`ifdef SDRAM_WRITE_MASK_EN
                    data_mask_n = ~wmask[3:2];
`endif
                    state_n    = WR_BOT;
                end
                WR_BOT: begin
                    command_n  = CMD_WRITE;
                    addr_n     = {4'b0000, laddress[7:1], 1'b1};
                    data_out_n = wdata[15:0];
                    data_oe_n  = 1'b1;
`ifdef SDRAM_WRITE_MASK_EN
                    data_mask_n = ~wmask[1:0];
`endif
                    laddress_n = laddress + 22'd2;
                    delay_n    = D_WR;
                    state_n    = PRECHARGE;
                end
                PRECHARGE: begin
                    // bank register still holds the ACT bank; laddress may already have carried.
                    command_n = CMD_PRE;
                    addr_n    = '0;
                    delay_n   = D_RP;
                    state_n   = DECIDE;
                end
                DECIDE: begin
                    if (lauto_refresh) begin
                        command_n       = CMD_AR;
                        lauto_refresh_n = 1'b0;
                        delay_n         = D_RFC;
                        state_n         = REFRESH;
                    end else if (en && !fifo_empty) begin
                        fifo_rd_n = 1'b1;
                        state_n   = FETCH;
                    end else begin
                        state_n = IDLE;
                    end
                end
                REFRESH: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        // A request arriving in the same cycle an AR issues must not be lost.
        if (auto_refresh && en)
            lauto_refresh_n = 1'b1;
    end
endmodule

// File: tb/tb_sdram_write.sv
// Scoreboard bench for sdram_write: expected SDRAM commands are queued with each FIFO word
// and compared (fields and spacing) as non-NOP commands appear on the bus.
module tb_sdram_write;
    localparam int T_RCD = 3, T_WR = 2, T_RP = 3, T_RFC = 10;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, WR = 3'b100, PRE = 3'b010, AR = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  command;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic [15:0] data_out;
    logic        data_oe;
    logic [1:0]  data_mask;
    logic        en = 1'b0;
    logic [21:0] address = '0;
    logic        ready;
    logic        auto_refresh = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_empty;
    logic        fifo_rd;
`ifdef SDRAM_WRITE_MASK_EN
    logic [3:0]  fifo_mask = '0;
    logic [3:0]  stim_mask [0:63];
`endif

    typedef struct {
        logic [2:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [15:0] data;
        logic [1:0]  mask;
        int          gap;
        bit          chk_ab;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] stim_data [0:63];
    int          stim_n = 0;
    int          rd_idx = 0;
    int          rd_pulses = 0;
    int          ncyc = 0;
    int          last_cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    sdram_write #(.T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
        .clk(clk), .rst(rst), .command(command), .addr(addr), .bank(bank),
        .data_out(data_out), .data_oe(data_oe), .data_mask(data_mask), .en(en),
        .address(address), .ready(ready), .auto_refresh(auto_refresh),
        .fifo_data(fifo_data),
`ifdef SDRAM_WRITE_MASK_EN
        .fifo_mask(fifo_mask),
`endif
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FIFO model: word is presented the cycle after the pop strobe.
    assign fifo_empty = (rd_idx >= stim_n);
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= stim_data[rd_idx];
`ifdef SDRAM_WRITE_MASK_EN
            fifo_mask <= stim_mask[rd_idx];
`endif
            rd_idx    <= rd_idx + 1;
        end
    end

    always @(negedge clk) begin
        ncyc++;
        if (!rst) begin
            check("data_oe", 32'(data_oe), 32'(command == WR));
            if (fifo_rd) rd_pulses++;
            if (command != NOP) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", 32'(command), 32'(NOP));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd", 32'(command), 32'(mon_e.cmd));
                    check("data_mask", 32'(data_mask), 32'(mon_e.mask));
                    if (mon_e.chk_ab) begin
                        check("addr", 32'(addr), 32'(mon_e.addr));
                        check("bank", 32'(bank), 32'(mon_e.bank));
                    end
                    if (mon_e.cmd == WR) check("data_out", 32'(data_out), 32'(mon_e.data));
                    if (mon_e.gap >= 0) check("gap", 32'(ncyc - last_cyc), 32'(mon_e.gap));
                end
                last_cyc = ncyc;
            end
        end
    end

    task automatic push_word(input logic [21:0] a, input logic [31:0] d, input logic [3:0] m,
                             input int act_gap, input bit only_act);
        exp_t        e;
        logic [21:0] la;
        logic [1:0]  mt, mb;
        la = a & 22'h3FFFFE;
`ifdef SDRAM_WRITE_MASK_EN
        mt = ~m[3:2];
        mb = ~m[1:0];
        stim_mask[stim_n] = m;
`else
        mt = 2'b00;
        mb = 2'b00;
        if (m == 4'hx) mt = 2'b00;
`endif
        stim_data[stim_n] = d;
        e.cmd = ACT; e.addr = la[19:8]; e.bank = la[21:20]; e.data = '0; e.mask = 2'b00;
        e.gap = act_gap; e.chk_ab = 1'b1;
        exp_q.push_back(e);
        if (!only_act) begin
            e.cmd = WR; e.addr = {4'b0000, la[7:0]}; e.data = d[31:16]; e.mask = mt; e.gap = T_RCD;
            exp_q.push_back(e);
            e.addr = {4'b0000, la[7:1], 1'b1}; e.data = d[15:0]; e.mask = mb; e.gap = 1;
            exp_q.push_back(e);
            e.cmd = PRE; e.addr = '0; e.data = '0; e.mask = 2'b00; e.gap = T_WR;
            exp_q.push_back(e);
        end
        stim_n++;
    endtask

    task automatic push_ar(input int gap);
        exp_t e;
        e.cmd = AR; e.addr = '0; e.bank = '0; e.data = '0; e.mask = 2'b00; e.gap = gap; e.chk_ab = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_cmd(input logic [2:0] c, input string tag);
        int n;
        n = 0;
        while (command !== c && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(command == c), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && ready) && n < 300);
        check(tag, 32'(ready && exp_q.size() == 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_command", 32'(command), 32'(NOP));
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_bank", 32'(bank), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_oe", 32'(data_oe), 32'd0);
        check("rst_data_mask", 32'(data_mask), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(negedge clk);

        // single word, bank 2 row ABC column 10
        p0 = rd_pulses;
        address = 22'h2ABC10;
        push_word(22'h2ABC10, 32'hDEADBEEF, 4'b1001, -1, 1'b0);
        en = 1'b1;
        wait_done("t1_done");
        check("t1_pops", 32'(rd_pulses - p0), 32'd1);

        // two words back to back; second continues at row 124 column 00
        p0 = rd_pulses;
        address = 22'h0123FE;
        push_word(22'h0123FE, 32'h11112222, 4'hF, -1, 1'b0);
        push_word(22'h012400, 32'h33334444, 4'hF, 6 - 1, 1'b0);
        wait_done("t2_done");
        check("t2_pops", 32'(rd_pulses - p0), 32'd2);
        repeat (8) @(negedge clk);
        check("t2_no_third_pop", 32'(rd_pulses - p0), 32'd2);

        // top-of-memory wrap to bank 0 row 000
        p0 = rd_pulses;
        address = 22'h3FFFFE;
        push_word(22'h3FFFFE, 32'hA5A5C3C3, 4'hF, -1, 1'b0);
        push_word(22'h000000, 32'h0F0F7E7E, 4'hF, 5, 1'b0);
        wait_done("t3_done");
        check("t3_pops", 32'(rd_pulses - p0), 32'd2);

        // refresh request during WR_TOP: AR T_RP after PRE; the following word is
        // re-fetched from IDLE, so its ACT follows AR by T_RFC plus REFRESH/FETCH/ACTIVATE.
        p0 = rd_pulses;
        address = 22'h100200;
        push_word(22'h100200, 32'hCAFEF00D, 4'hF, -1, 1'b0);
        push_ar(T_RP);
        push_word(22'h0ABCDF, 32'h12345678, 4'hF, T_RFC + 3, 1'b0);
        wait_cmd(ACT, "t4_first_act");
        #1;
        auto_refresh = 1'b1;
        address = 22'h0ABCDF;
        @(negedge clk);
        auto_refresh = 1'b0;
        wait_done("t4_done");
        check("t4_pops", 32'(rd_pulses - p0), 32'd2);

        // refresh pulse while disabled is ignored
        en = 1'b0;
        auto_refresh = 1'b1;
        @(negedge clk);
        auto_refresh = 1'b0;
        en = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_ready", 32'(ready), 32'd1);

        // reset during the ACT->WRITE delay aborts the word
        address = 22'h155554;
        push_word(22'h155554, 32'h99998888, 4'hF, -1, 1'b1);
        wait_cmd(ACT, "t6_act");
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6_command", 32'(command), 32'(NOP));
        check("t6_data_oe", 32'(data_oe), 32'd0);
        check("t6_fifo_rd", 32'(fifo_rd), 32'd0);
        check("t6_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        p0 = rd_pulses;
        repeat (12) @(negedge clk);
        check("t6_no_pop", 32'(rd_pulses - p0), 32'd0);
        check("t6_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
